// File: rtl/conv_mac_seq.sv
// Sequential convolution MAC: one kernel window in, one signed result out.
// Ports: clk, rst (async high), in_valid/in_ready + data/weight/bias in,
//        out_valid/out_ready + result out.
module conv_mac_seq #(
  parameter int BITWIDTH     = 8,
  parameter int DATACHANNEL  = 3,
  parameter int FILTERHEIGHT = 5,
  parameter int FILTERWIDTH  = 5,
  parameter int LANES        = 5,
  parameter int SATURATE     = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  output logic in_ready,
  input  logic [BITWIDTH*DATACHANNEL*FILTERHEIGHT*FILTERWIDTH-1:0] data,
  input  logic [BITWIDTH*DATACHANNEL*FILTERHEIGHT*FILTERWIDTH-1:0] weight,
  input  logic [BITWIDTH-1:0] bias,
  output logic out_valid,
  input  logic out_ready,
  output logic [2*BITWIDTH-1:0] result
);

  localparam int N    = DATACHANNEL*FILTERHEIGHT*FILTERWIDTH;
  localparam bit BAD  = (LANES < 1) ? 1'b1 : ((N % LANES) != 0);
  localparam int G    = (LANES < 1) ? 1 : N / LANES;
  localparam int BW   = BITWIDTH;
  localparam int RW   = 2*BITWIDTH;
  localparam int GW   = LANES*BITWIDTH;
  localparam int ACCW = 2*BITWIDTH + $clog2(N) + 1;
  localparam int CW   = (G > 1) ? $clog2(G) : 1;

  localparam logic signed [ACCW-1:0] RMAX =
    {{(ACCW-RW+1){1'b0}}, {(RW-1){1'b1}}};
  localparam logic signed [ACCW-1:0] RMIN =
    {{(ACCW-RW+1){1'b1}}, {(RW-1){1'b0}}};

  if (BAD) begin : g_bad_cfg
    $error("conv_mac_seq: N must be a multiple of LANES, LANES >= 1");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                  state_q, state_d;
  logic [BW*N-1:0]         data_q, wgt_q;
  logic signed [ACCW-1:0]  acc_q, acc_d, grp_sum;
  logic [CW-1:0]           cnt_q;
  logic [RW-1:0]           res_d, result_q;
  logic                    last;
  logic signed [RW-1:0]    prod [LANES];

  assign last   = (cnt_q == CW'(G-1));
  assign result = result_q;

  // Operands shift down one group per BUSY cycle, so the
  // current group always sits in the low LANES taps.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [BW-1:0] dl, wl;
    assign dl = data_q[l*BW +: BW];
    assign wl = wgt_q[l*BW +: BW];
    assign prod[l] = $signed({{BW{dl[BW-1]}}, dl})
                   * $signed({{BW{wl[BW-1]}}, wl});
  end

  always_comb begin
    grp_sum = '0;
    for (int l = 0; l < LANES; l++) begin
      grp_sum = grp_sum + ACCW'(prod[l]);
    end
  end

  assign acc_d = acc_q + grp_sum;

  always_comb begin
    res_d = acc_d[RW-1:0];
    if (SATURATE != 0) begin
      if (acc_d > RMAX)      res_d = RMAX[RW-1:0];
      else if (acc_d < RMIN) res_d = RMIN[RW-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid)  state_d = BUSY;
      BUSY:    if (last)      state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE:    in_ready  = 1'b1;
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q   <= '0;
      wgt_q    <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: if (in_valid) begin
          data_q <= data;
          wgt_q  <= weight;
          acc_q  <= ACCW'($signed(bias));
          cnt_q  <= '0;
        end
        BUSY: begin
          acc_q  <= acc_d;
          cnt_q  <= cnt_q + CW'(1);
          data_q <= data_q >> GW;
          wgt_q  <= wgt_q >> GW;
          if (last) result_q <= res_d;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_mac_seq.sv
// Directed bench for conv_mac_seq: saturating and wrapping instances
// share stimulus; results checked against hand-computed values.
module tb_conv_mac_seq;

  localparam int BW = 8;
  localparam int N  = 75;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst, in_valid, out_ready;
  logic [BW*N-1:0] data, weight;
  logic [BW-1:0]   bias;
  logic            in_ready_s, out_valid_s, in_ready_w, out_valid_w;
  logic [2*BW-1:0] result_s, result_w;

  int checks = 0;
  int errors = 0;

  conv_mac_seq #(.SATURATE(1)) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
    .data(data), .weight(weight), .bias(bias),
    .out_valid(out_valid_s), .out_ready(out_ready), .result(result_s)
  );

  conv_mac_seq #(.SATURATE(0)) u_wrap (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w),
    .data(data), .weight(weight), .bias(bias),
    .out_valid(out_valid_w), .out_ready(out_ready), .result(result_w)
  );

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int rs();
    return int'($signed(result_s));
  endfunction

  function automatic int rw();
    return int'($signed(result_w));
  endfunction

  task automatic fill(input int d, input int w, input int b);
    for (int i = 0; i < N; i++) begin
      data[i*BW +: BW]   = d[BW-1:0];
      weight[i*BW +: BW] = w[BW-1:0];
    end
    bias = b[BW-1:0];
  endtask

  task automatic scramble();
    for (int i = 0; i < N; i++) begin
      data[i*BW +: BW]   = 8'($urandom);
      weight[i*BW +: BW] = 8'($urandom);
    end
    bias = 8'($urandom);
  endtask

  task automatic accept(input string tag);
    @(negedge clk);
    in_valid = 1'b1;
    chk({tag, "_in_ready"}, int'(in_ready_s), 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input bit scr);
    int n = 0;
    while (!out_valid_s && n < 40) begin
      if (scr) begin
        scramble();
        in_valid = 1'b1;
      end
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk({tag, "_latency"}, n, 15);
    chk({tag, "_wrap_valid"}, int'(out_valid_w), 1);
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_idle_ready"}, int'(in_ready_s), 1);
    chk({tag, "_idle_valid"}, int'(out_valid_s), 0);
  endtask

  task automatic window(input string tag, input int es,
                        input int ew, input bit scr);
    accept(tag);
    wait_done(tag, scr);
    chk({tag, "_sat"}, rs(), es);
    chk({tag, "_wrap"}, rw(), ew);
    handshake(tag);
  endtask

  task automatic hold_test();
    fill(1, 1, 0);
    accept("hold");
    wait_done("hold", 1'b0);
    for (int c = 0; c < 10; c++) begin
      scramble();
      in_valid = c[0];
      @(posedge clk);
      @(negedge clk);
      chk("hold_result", rs(), 75);
      chk("hold_valid", int'(out_valid_s), 1);
      chk("hold_in_ready", int'(in_ready_s), 0);
    end
    in_valid = 1'b0;
    handshake("hold");
  endtask

  task automatic b2b_test();
    int k  = 0;
    int nf = 0;
    int t [2];
    int r [2];
    @(negedge clk);
    fill(1, 1, 0);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    fill(2, -3, 5);
    while (nf < 2 && k < 60) begin
      if (out_valid_s) begin
        t[nf] = k;
        r[nf] = rs();
        nf++;
      end
      @(posedge clk);
      k++;
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("b2b_count", nf, 2);
    if (nf == 2) begin
      chk("b2b_first_at", t[0], 15);
      chk("b2b_period", t[1] - t[0], 17);
      chk("b2b_res0", r[0], 75);
      chk("b2b_res1", r[1], -445);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    fill(0, 0, 0);
    repeat (2) @(negedge clk);
    chk("rst_valid", int'(out_valid_s), 0);
    chk("rst_result", rs(), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", int'(in_ready_s), 1);

    fill(1, 1, 0);
    window("ones", 75, 75, 1'b0);

    fill(127, 127, 127);
    window("max", 32767, 30154, 1'b1);

    fill(-128, 127, -128);
    window("min", -32768, 25856, 1'b0);

    // Mismatched taps 1/2 catch any lane or group misalignment.
    fill(0, 0, 3);
    data[0*BW +: BW]    = 8'd5;
    weight[0*BW +: BW]  = 8'd6;
    data[1*BW +: BW]    = 8'd50;
    weight[2*BW +: BW]  = 8'd50;
    data[74*BW +: BW]   = 8'd100;
    weight[74*BW +: BW] = 8'(-100);
    window("sparse", -9967, -9967, 1'b0);

    hold_test();

    fill(1, 1, 0);
    accept("rbusy");
    repeat (8) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rbusy_valid", int'(out_valid_s), 0);
    chk("rbusy_result", rs(), 0);
    chk("rbusy_wrap_result", rw(), 0);
    @(negedge clk);
    rst = 1'b0;
    fill(2, -3, 5);
    window("post_rst", -445, -445, 1'b0);

    fill(1, 1, 0);
    accept("rdone");
    wait_done("rdone", 1'b0);
    rst = 1'b1;
    #1;
    chk("rdone_valid", int'(out_valid_s), 0);
    chk("rdone_result", rs(), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rdone_in_ready", int'(in_ready_s), 1);
    chk("rdone_no_valid", int'(out_valid_s), 0);

    b2b_test();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
